// File: rtl/regwr_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, LLU results queue in a FIFO.
// Optional starvation guard enabled by defining REGWR_STARVE_GUARD_EN.
module regwr_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_write,
    input  logic [5:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    output logic                       wb_stall,
    input  logic                       llu_valid,
    input  logic [5:0]                 llu_rd,
    input  logic [31:0]                llu_data,
    output logic                       llu_ready,
    input  logic [5:0]                 q_rd,
    output logic                       q_hit,
    output logic [$clog2(DEPTH):0]     pend_count,
    output logic [5:0]                 regno,
    output logic [31:0]                regdata,
    output logic                       write
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("regwr_arbiter: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
    end

    logic [5:0]  mem_rd   [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    logic full, empty, wb_req, pipe_write, deq, enq;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign llu_ready  = !rst && !full;
    assign enq        = llu_valid && llu_ready && (llu_rd != 6'd0);
    assign wb_req     = wb_write && (wb_rd != 6'd0);
    assign pipe_write = !rst && wb_req && !wb_stall;
    assign deq        = !rst && !pipe_write && !empty;
    assign write      = pipe_write || deq;
    assign regno      = pipe_write ? wb_rd   : mem_rd[rd_ptr];
    assign regdata    = pipe_write ? wb_data : mem_data[rd_ptr];
    assign pend_count = count;

`ifdef REGWR_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_cnt;

    // Once the counter saturates at the limit the head is forced out ahead of the pipeline.
    assign wb_stall = !rst && !empty && (starve_cnt == SW'(STARVE_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (empty || deq) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    assign wb_stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            if (enq && !deq)      count <= count + 1'b1;
            else if (!enq && deq) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            mem_rd[wr_ptr]   <= llu_rd;
            mem_data[wr_ptr] <= llu_data;
        end
    end

    // Hazard match walks occupied slots from the head; the entry being written this cycle is not yet counted.
    always_comb begin
        logic [AW-1:0] idx;
        logic          hit;
        hit = 1'b0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + i[AW-1:0];
            if ((AW+1)'(i) < count && mem_rd[idx] == q_rd) hit = 1'b1;
        end
        q_hit = hit && (q_rd != 6'd0) && !rst;
    end

endmodule

// File: tb/tb_regwr_arbiter.sv
// Directed, table-driven bench for regwr_arbiter (DEPTH=4, STARVE_LIMIT=8).
module tb_regwr_arbiter;

    logic        clk, rst;
    logic        wb_write, llu_valid;
    logic [5:0]  wb_rd, llu_rd, q_rd, regno;
    logic [31:0] wb_data, llu_data, regdata;
    logic        wb_stall, llu_ready, q_hit, write;
    logic [2:0]  pend_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wb_write;
        logic [5:0]  wb_rd;
        logic [31:0] wb_data;
        logic        llu_valid;
        logic [5:0]  llu_rd;
        logic [31:0] llu_data;
        logic [5:0]  q_rd;
        logic        exp_write;
        logic [5:0]  exp_regno;
        logic [31:0] exp_regdata;
        logic        exp_ready;
        logic        exp_hit;
        logic [2:0]  exp_pend;
    } vec_t;

    vec_t vecs[12];

    regwr_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data), .wb_stall(wb_stall),
        .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
        .q_rd(q_rd), .q_hit(q_hit), .pend_count(pend_count),
        .regno(regno), .regdata(regdata), .write(write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wb_write  = v.wb_write;
        wb_rd     = v.wb_rd;
        wb_data   = v.wb_data;
        llu_valid = v.llu_valid;
        llu_rd    = v.llu_rd;
        llu_data  = v.llu_data;
        q_rd      = v.q_rd;
    endtask

    task automatic drive(input logic ww, input logic [5:0] wr, input logic [31:0] wd,
                         input logic lv, input logic [5:0] lr, input logic [31:0] ld,
                         input logic [5:0] qr);
        vec_t v;
        v = '{ww, wr, wd, lv, lr, ld, qr, 1'b0, 6'd0, 32'd0, 1'b0, 1'b0, 3'd0};
        applyStimulus(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [5:0]  m_rd[$];
    logic [31:0] m_data[$];

    initial begin
        // Cycle-by-cycle vectors: inputs, then outputs expected before the next edge
        vecs[0]  = '{0, 6'd0,  32'h0,  1, 6'd7,  32'hDEADBEEF, 6'd7,  0, 6'd0,  32'h0,        1, 0, 3'd0};
        vecs[1]  = '{0, 6'd0,  32'h0,  0, 6'd0,  32'h0,        6'd7,  1, 6'd7,  32'hDEADBEEF, 1, 1, 3'd1};
        vecs[2]  = '{0, 6'd0,  32'h0,  1, 6'd0,  32'h1234,     6'd0,  0, 6'd0,  32'h0,        1, 0, 3'd0};
        vecs[3]  = '{1, 6'd1,  32'h11, 1, 6'd3,  32'h300,      6'd3,  1, 6'd1,  32'h11,       1, 0, 3'd0};
        vecs[4]  = '{1, 6'd2,  32'h22, 1, 6'd9,  32'h900,      6'd9,  1, 6'd2,  32'h22,       1, 0, 3'd1};
        vecs[5]  = '{1, 6'd4,  32'h44, 1, 6'd10, 32'hA00,      6'd9,  1, 6'd4,  32'h44,       1, 1, 3'd2};
        vecs[6]  = '{1, 6'd5,  32'h55, 1, 6'd11, 32'hB00,      6'd4,  1, 6'd5,  32'h55,       1, 0, 3'd3};
        vecs[7]  = '{1, 6'd6,  32'h66, 1, 6'd12, 32'hC00,      6'd0,  1, 6'd6,  32'h66,       0, 0, 3'd4};
        vecs[8]  = '{1, 6'd8,  32'h88, 1, 6'd12, 32'hC00,      6'd11, 1, 6'd8,  32'h88,       0, 1, 3'd4};
        vecs[9]  = '{1, 6'd0,  32'h99, 1, 6'd12, 32'hC00,      6'd3,  1, 6'd3,  32'h300,      0, 1, 3'd4};
        vecs[10] = '{1, 6'd13, 32'hD0, 1, 6'd12, 32'hC00,      6'd3,  1, 6'd13, 32'hD0,       1, 0, 3'd3};
        vecs[11] = '{1, 6'd14, 32'hE0, 0, 6'd0,  32'h0,        6'd12, 1, 6'd14, 32'hE0,       0, 1, 3'd4};

        // Reset with a pipeline write held: no write until release, then immediate write
        rst = 1'b1;
        drive(1, 6'd5, 32'h55, 0, 6'd0, 32'h0, 6'd5);
        repeat (3) begin
            @(negedge clk);
            checkOutput("rst_write", write, 0);
            checkOutput("rst_stall", wb_stall, 0);
            checkOutput("rst_ready", llu_ready, 0);
            checkOutput("rst_hit", q_hit, 0);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        checkOutput("rel_write", write, 1);
        checkOutput("rel_regno", regno, 5);
        checkOutput("rel_regdata", regdata, 32'h55);
        checkOutput("rel_ready", llu_ready, 1);
        next_cycle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("v%0d_write", i), write, vecs[i].exp_write);
            if (vecs[i].exp_write) begin
                checkOutput($sformatf("v%0d_regno", i), regno, vecs[i].exp_regno);
                checkOutput($sformatf("v%0d_regdata", i), regdata, vecs[i].exp_regdata);
            end
            checkOutput($sformatf("v%0d_ready", i), llu_ready, vecs[i].exp_ready);
            checkOutput($sformatf("v%0d_hit", i), q_hit, vecs[i].exp_hit);
            checkOutput($sformatf("v%0d_pend", i), pend_count, vecs[i].exp_pend);
            checkOutput($sformatf("v%0d_stall", i), wb_stall, 0);
            next_cycle();
        end

        // Streaming enqueue while draining from a full FIFO; pointers wrap several times
        m_rd   = '{6'd9, 6'd10, 6'd11, 6'd12};
        m_data = '{32'h900, 32'hA00, 32'hB00, 32'hC00};
        for (int i = 0; i < 13; i++) begin
            logic exp_ready;
            logic lv;
            lv = (i < 10);
            drive(0, 6'd0, 32'h0, lv, 6'(20 + i), 32'h1000 + i, 6'd0);
            exp_ready = (m_rd.size() < 4);
            @(negedge clk);
            checkOutput($sformatf("s%0d_pend", i), pend_count, m_rd.size());
            checkOutput($sformatf("s%0d_ready", i), llu_ready, exp_ready);
            checkOutput($sformatf("s%0d_write", i), write, m_rd.size() > 0);
            if (m_rd.size() > 0) begin
                checkOutput($sformatf("s%0d_regno", i), regno, m_rd[0]);
                checkOutput($sformatf("s%0d_regdata", i), regdata, m_data[0]);
                void'(m_rd.pop_front());
                void'(m_data.pop_front());
            end
            if (lv && exp_ready) begin
                m_rd.push_back(6'(20 + i));
                m_data.push_back(32'h1000 + i);
            end
            next_cycle();
        end
        @(negedge clk);
        checkOutput("s_end_pend", pend_count, 0);

        // Reset in the middle of operation discards queued entries
        next_cycle();
        drive(1, 6'd1, 32'h1, 1, 6'd21, 32'h21, 6'd21);
        next_cycle();
        drive(1, 6'd2, 32'h2, 1, 6'd22, 32'h22, 6'd21);
        next_cycle();
        drive(0, 6'd0, 32'h0, 0, 6'd0, 32'h0, 6'd21);
        @(negedge clk);
        checkOutput("mr_pend_before", pend_count, 2);
        rst = 1'b1;
        #1;
        checkOutput("mr_pend_in_rst", pend_count, 0);
        checkOutput("mr_write_in_rst", write, 0);
        next_cycle();
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("mr_write_after", write, 0);
            checkOutput("mr_pend_after", pend_count, 0);
            checkOutput("mr_hit_after", q_hit, 0);
        end
        next_cycle();

        // Pipeline busy every cycle with one queued LLU entry
        drive(1, 6'd1, 32'hAA, 1, 6'd17, 32'h1717, 6'd0);
        next_cycle();
        drive(1, 6'd1, 32'hAA, 0, 6'd0, 32'h0, 6'd0);
`ifdef REGWR_STARVE_GUARD_EN
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            checkOutput($sformatf("g%0d_stall", c), wb_stall, c == 9);
            checkOutput($sformatf("g%0d_write", c), write, 1);
            checkOutput($sformatf("g%0d_regno", c), regno, (c == 9) ? 6'd17 : 6'd1);
            checkOutput($sformatf("g%0d_pend", c), pend_count, (c <= 9) ? 3'd1 : 3'd0);
            next_cycle();
        end
`else
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("g%0d_stall", c), wb_stall, 0);
            checkOutput($sformatf("g%0d_regno", c), regno, 6'd1);
            checkOutput($sformatf("g%0d_pend", c), pend_count, 3'd1);
            next_cycle();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
